// File: rtl/pivot_col_extract.sv
// Splits a row-major tableau stream into pivot-column and RHS-column streams
// for the ratio-test stage, skipping the objective row.
module pivot_col_extract #(
    parameter int ELEMW = 32,
    parameter int DATAW = ELEMW
) (
    input  logic             clk,
    input  logic             areset,
    input  logic             start,
    input  logic [15:0]      num_rows,
    input  logic [15:0]      num_cols,
    input  logic [15:0]      pivot_col,
    input  logic [DATAW-1:0] axi_tableau_data,
    input  logic             axi_tableau_valid,
    input  logic             axi_tableau_last,
    output logic             axi_tableau_ready,
    output logic [DATAW-1:0] axi_pivotcol_data,
    output logic             axi_pivotcol_valid,
    input  logic             axi_pivotcol_ready,
    output logic [DATAW-1:0] axi_rightcol_data,
    output logic             axi_rightcol_valid,
    input  logic             axi_rightcol_ready,
    output logic             busy,
    output logic             done,
    output logic             error
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_ERROR = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_next_state;
    logic [15:0]      r_rows;
    logic [15:0]      r_cols;
    logic [15:0]      r_piv_col;
    logic [15:0]      r_col;
    logic [15:0]      r_row;
    logic [DATAW-1:0] r_stage_piv;
    logic [DATAW-1:0] r_piv_data;
    logic [DATAW-1:0] r_rhs_data;
    logic             r_piv_valid;
    logic             r_rhs_valid;
    logic             r_done;
    logic             r_error;
    logic             r_busy;

    logic w_cfg_bad;
    logic w_start_ok;
    logic w_col_wrap;
    logic w_rhs_beat;
    logic w_final;
    logic w_last_err;
    logic w_ready;
    logic w_accept;

    assign w_cfg_bad  = (num_rows < 16'd2) || (num_cols < 16'd2) ||
                        (pivot_col >= (num_cols - 16'd1));
    assign w_start_ok = start && ((r_state == S_IDLE) || (r_state == S_ERROR));
    assign w_col_wrap = (r_col == (r_cols - 16'd1));
    assign w_rhs_beat = (r_row != 16'd0) && w_col_wrap;
    assign w_final    = (r_row == (r_rows - 16'd1)) && w_col_wrap;
    assign w_last_err = (axi_tableau_last != w_final);
    // An RHS beat may only land when the previous pair has fully left both sides.
    assign w_ready    = (r_state == S_RUN) && !(w_rhs_beat && (r_piv_valid || r_rhs_valid));
    assign w_accept   = axi_tableau_valid && w_ready;

    assign axi_tableau_ready  = w_ready;
    assign axi_pivotcol_data  = r_piv_data;
    assign axi_pivotcol_valid = r_piv_valid;
    assign axi_rightcol_data  = r_rhs_data;
    assign axi_rightcol_valid = r_rhs_valid;
    assign busy               = r_busy;
    assign done               = r_done;
    assign error              = r_error;

    // State register.
    always_ff @(posedge clk) begin
        if (areset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE, S_ERROR: begin
                if (start) begin
                    w_next_state = w_cfg_bad ? S_ERROR : S_RUN;
                end else begin
                    w_next_state = r_state;
                end
            end
            S_RUN: begin
                if (w_accept && w_last_err) begin
                    w_next_state = S_IDLE;
                end else if (w_accept && w_final) begin
                    w_next_state = S_DRAIN;
                end else begin
                    w_next_state = S_RUN;
                end
            end
            S_DRAIN: begin
                if (!r_piv_valid && !r_rhs_valid) begin
                    w_next_state = S_IDLE;
                end else begin
                    w_next_state = S_DRAIN;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    // Configuration, position counters, staging and status flags.
    always_ff @(posedge clk) begin
        if (areset) begin
            r_rows      <= 16'd0;
            r_cols      <= 16'd0;
            r_piv_col   <= 16'd0;
            r_col       <= 16'd0;
            r_row       <= 16'd0;
            r_stage_piv <= {DATAW{1'b0}};
            r_error     <= 1'b0;
            r_done      <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_done <= (r_state == S_DRAIN) && !r_piv_valid && !r_rhs_valid;
            r_busy <= (w_next_state == S_RUN) || (w_next_state == S_DRAIN);
            if (w_start_ok) begin
                r_rows    <= num_rows;
                r_cols    <= num_cols;
                r_piv_col <= pivot_col;
                r_col     <= 16'd0;
                r_row     <= 16'd0;
                r_error   <= w_cfg_bad;
            end else if (w_accept) begin
                if (w_col_wrap) begin
                    r_col <= 16'd0;
                    r_row <= r_row + 16'd1;
                end else begin
                    r_col <= r_col + 16'd1;
                end
                if ((r_row != 16'd0) && (r_col == r_piv_col)) begin
                    r_stage_piv <= axi_tableau_data;
                end
                if (w_last_err) begin
                    r_error <= 1'b1;
                end
            end
        end
    end

    // Output pair registers; each side is released by its own handshake.
    always_ff @(posedge clk) begin
        if (areset) begin
            r_piv_data  <= {DATAW{1'b0}};
            r_rhs_data  <= {DATAW{1'b0}};
            r_piv_valid <= 1'b0;
            r_rhs_valid <= 1'b0;
        end else if (w_accept && w_rhs_beat) begin
            r_piv_data  <= r_stage_piv;
            r_rhs_data  <= axi_tableau_data;
            r_piv_valid <= 1'b1;
            r_rhs_valid <= 1'b1;
        end else begin
            if (r_piv_valid && axi_pivotcol_ready) begin
                r_piv_valid <= 1'b0;
            end
            if (r_rhs_valid && axi_rightcol_ready) begin
                r_rhs_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_pivot_col_extract.sv
// Scoreboard bench for pivot_col_extract: expected pairs are derived from the
// tableau contents and popped by independent output monitors.
module tb_pivot_col_extract;

    logic        clk = 1'b0;
    logic        areset;
    logic        start;
    logic [15:0] num_rows, num_cols, pivot_col;
    logic [31:0] axi_tableau_data;
    logic        axi_tableau_valid, axi_tableau_last, axi_tableau_ready;
    logic [31:0] axi_pivotcol_data;
    logic        axi_pivotcol_valid, axi_pivotcol_ready;
    logic [31:0] axi_rightcol_data;
    logic        axi_rightcol_valid, axi_rightcol_ready;
    logic        busy, done, error;

    pivot_col_extract #(.ELEMW(32)) dut (
        .clk(clk), .areset(areset), .start(start),
        .num_rows(num_rows), .num_cols(num_cols), .pivot_col(pivot_col),
        .axi_tableau_data(axi_tableau_data), .axi_tableau_valid(axi_tableau_valid),
        .axi_tableau_last(axi_tableau_last), .axi_tableau_ready(axi_tableau_ready),
        .axi_pivotcol_data(axi_pivotcol_data), .axi_pivotcol_valid(axi_pivotcol_valid),
        .axi_pivotcol_ready(axi_pivotcol_ready),
        .axi_rightcol_data(axi_rightcol_data), .axi_rightcol_valid(axi_rightcol_valid),
        .axi_rightcol_ready(axi_rightcol_ready),
        .busy(busy), .done(done), .error(error)
    );

    always #5 clk = ~clk;

    logic [31:0] tab [0:7][0:7];
    logic [31:0] exp_piv_q[$];
    logic [31:0] exp_rhs_q[$];
    int n_tests = 0;
    int n_fail = 0;
    int done_cnt = 0;
    int stall_cnt = 0;
    int rdy_mode = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Downstream ready generator
    initial begin
        forever begin
            @(posedge clk); #1;
            if (rdy_mode == 0) begin
                axi_pivotcol_ready = 1'b1;
                axi_rightcol_ready = 1'b1;
            end else if (rdy_mode == 1) begin
                axi_pivotcol_ready = ($urandom_range(0, 2) != 0);
                axi_rightcol_ready = ($urandom_range(0, 2) != 0);
            end
        end
    end

    // Output monitors: each side pops its own queue on its own handshake
    initial begin
        logic [31:0] e;
        forever begin
            @(negedge clk);
            if (done) done_cnt++;
            if (axi_pivotcol_valid && axi_pivotcol_ready) begin
                if (exp_piv_q.size() == 0) chk("piv_unexpected", 32'd1, 32'd0);
                else begin
                    e = exp_piv_q.pop_front();
                    chk("piv_data", axi_pivotcol_data, e);
                end
            end
            if (axi_rightcol_valid && axi_rightcol_ready) begin
                if (exp_rhs_q.size() == 0) chk("rhs_unexpected", 32'd1, 32'd0);
                else begin
                    e = exp_rhs_q.pop_front();
                    chk("rhs_data", axi_rightcol_data, e);
                end
            end
        end
    end

    // last_at: beat index carrying last (-1 = proper final beat, -2 = never)
    task automatic run_pass(input int rows, input int cols, input int pc, input int last_at,
                            input bit gaps, input int abort_after, input bit exp_bad_cfg);
        int final_idx, stop_idx, idx, acc, cyc, d0;
        bit bad_last, is_rhs, pend_lat;
        final_idx = rows * cols - 1;
        stop_idx  = (last_at >= 0) ? last_at : final_idx;
        bad_last  = (last_at == -2) || (last_at >= 0 && last_at != final_idx);
        d0 = done_cnt;
        pend_lat = 1'b0;
        @(posedge clk); #1;
        start = 1'b1; num_rows = 16'(rows); num_cols = 16'(cols); pivot_col = 16'(pc);
        @(posedge clk); #1;
        start = 1'b0;
        if (exp_bad_cfg) begin
            repeat (3) @(negedge clk);
            chk("badcfg_error", {31'd0, error}, 32'd1);
            chk("badcfg_ready", {31'd0, axi_tableau_ready}, 32'd0);
            chk("badcfg_valids", {30'd0, axi_pivotcol_valid, axi_rightcol_valid}, 32'd0);
            return;
        end
        @(negedge clk);
        chk("start_busy", {31'd0, busy}, 32'd1);
        chk("start_error_clear", {31'd0, error}, 32'd0);
        // Reference: one (pivot, RHS) pair per constraint row up to where the pass stops
        for (int r = 1; r < rows; r++) begin
            if (r * cols + cols - 1 <= stop_idx) begin
                exp_piv_q.push_back(tab[r][pc]);
                exp_rhs_q.push_back(tab[r][cols-1]);
            end
        end
        idx = 0; acc = 0; cyc = 0;
        while (idx <= stop_idx && cyc < 2000) begin
            @(posedge clk); #1;
            if (gaps && $urandom_range(0, 3) == 0) begin
                axi_tableau_valid = 1'b0;
            end else begin
                axi_tableau_valid = 1'b1;
                axi_tableau_data  = tab[idx / cols][idx % cols];
                axi_tableau_last  = (last_at != -2) && (idx == stop_idx);
            end
            @(negedge clk);
            cyc++;
            if (pend_lat) begin
                chk("pair_latency", {30'd0, axi_pivotcol_valid, axi_rightcol_valid}, 32'd3);
                pend_lat = 1'b0;
            end
            if (axi_tableau_valid) begin
                is_rhs = (idx / cols >= 1) && (idx % cols == cols - 1);
                if (!axi_tableau_ready) begin
                    stall_cnt++;
                    chk("stall_only_rhs_pending",
                        {31'd0, is_rhs && (axi_pivotcol_valid || axi_rightcol_valid)}, 32'd1);
                end else begin
                    if (is_rhs) begin
                        chk("rhs_accept_outputs_free",
                            {31'd0, axi_pivotcol_valid || axi_rightcol_valid}, 32'd0);
                        pend_lat = 1'b1;
                    end
                    idx++;
                    acc++;
                    if (abort_after >= 0 && acc == abort_after) break;
                end
            end
        end
        if (cyc >= 2000) chk("stream_timeout", 32'd1, 32'd0);
        if (abort_after >= 0) begin
            @(posedge clk); #1;
            axi_tableau_valid = 1'b0; axi_tableau_last = 1'b0; areset = 1'b1;
            @(posedge clk); #1;
            areset = 1'b0;
            @(negedge clk);
            chk("abort_ready", {31'd0, axi_tableau_ready}, 32'd0);
            chk("abort_valids", {30'd0, axi_pivotcol_valid, axi_rightcol_valid}, 32'd0);
            chk("abort_piv_data", axi_pivotcol_data, 32'd0);
            chk("abort_rhs_data", axi_rightcol_data, 32'd0);
            chk("abort_flags", {29'd0, busy, done, error}, 32'd0);
            exp_piv_q.delete();
            exp_rhs_q.delete();
            return;
        end
        @(posedge clk); #1;
        axi_tableau_valid = 1'b0; axi_tableau_last = 1'b0;
        @(negedge clk);
        if (pend_lat) chk("pair_latency", {30'd0, axi_pivotcol_valid, axi_rightcol_valid}, 32'd3);
        cyc = 0;
        while ((exp_piv_q.size() != 0 || exp_rhs_q.size() != 0 || busy ||
                axi_pivotcol_valid || axi_rightcol_valid) && cyc < 500) begin
            @(negedge clk);
            cyc++;
        end
        if (cyc >= 500) chk("drain_timeout", 32'd1, 32'd0);
        repeat (2) @(negedge clk);
        chk("pairs_all_delivered", 32'(exp_piv_q.size() + exp_rhs_q.size()), 32'd0);
        chk("done_pulses", 32'(done_cnt - d0), bad_last ? 32'd0 : 32'd1);
        chk("end_error", {31'd0, error}, {31'd0, bad_last});
        chk("end_busy", {31'd0, busy}, 32'd0);
    endtask

    task automatic load_basic();
        logic [31:0] f [0:9];
        f = '{32'h00000000, 32'h3f800000, 32'h40000000, 32'h40400000, 32'h40800000,
              32'h40a00000, 32'h40c00000, 32'h40e00000, 32'h41000000, 32'h41100000};
        tab[0][0] = f[0]; tab[0][1] = f[1]; tab[0][2] = f[2]; tab[0][3] = f[3];
        tab[1][0] = f[4]; tab[1][1] = f[2]; tab[1][2] = f[5]; tab[1][3] = f[6];
        tab[2][0] = f[7]; tab[2][1] = f[4]; tab[2][2] = f[8]; tab[2][3] = f[9];
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        n_fail++;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        int rr, cc, pp;
        areset = 1'b1; start = 1'b0;
        num_rows = 16'd0; num_cols = 16'd0; pivot_col = 16'd0;
        axi_tableau_data = 32'd0; axi_tableau_valid = 1'b0; axi_tableau_last = 1'b0;
        axi_pivotcol_ready = 1'b1; axi_rightcol_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_ready", {31'd0, axi_tableau_ready}, 32'd0);
        chk("reset_valids", {30'd0, axi_pivotcol_valid, axi_rightcol_valid}, 32'd0);
        chk("reset_data", axi_pivotcol_data | axi_rightcol_data, 32'd0);
        chk("reset_flags", {29'd0, busy, done, error}, 32'd0);
        @(posedge clk); #1;
        areset = 1'b0;

        // Basic pass
        load_basic();
        run_pass(3, 4, 1, -1, 1'b0, -1, 1'b0);

        // Backpressure on the RHS side only
        rdy_mode = 2; stall_cnt = 0;
        @(posedge clk); #1;
        axi_pivotcol_ready = 1'b1; axi_rightcol_ready = 1'b0;
        fork
            run_pass(3, 4, 1, -1, 1'b0, -1, 1'b0);
            begin
                int c;
                c = 0;
                while (!axi_rightcol_valid && c < 200) begin
                    @(negedge clk);
                    c++;
                end
                @(negedge clk);
                chk("bp_piv_independent",
                    {30'd0, axi_pivotcol_valid, axi_rightcol_valid}, 32'd1);
                repeat (3) @(negedge clk);
                @(posedge clk); #1;
                axi_rightcol_ready = 1'b1;
            end
        join
        chk("bp_stall_seen", {31'd0, stall_cnt != 0}, 32'd1);
        rdy_mode = 0;

        // Boundary column with sign-bearing patterns
        tab[0][0] = 32'h3f800000; tab[0][1] = 32'h3f800000;
        tab[1][0] = 32'hbf800000; tab[1][1] = 32'h40400000;
        tab[2][0] = 32'h00000000; tab[2][1] = 32'h40a00000;
        tab[3][0] = 32'h40000000; tab[3][1] = 32'hc0000000;
        run_pass(4, 2, 0, -1, 1'b0, -1, 1'b0);

        // Bad config, then recovery
        load_basic();
        run_pass(3, 4, 3, -1, 1'b0, -1, 1'b1);
        run_pass(3, 4, 1, -1, 1'b0, -1, 1'b0);

        // last too early, then last missing
        run_pass(3, 4, 1, 7, 1'b0, -1, 1'b0);
        run_pass(3, 4, 1, -2, 1'b0, -1, 1'b0);

        // Reset mid-pass, then a clean pass
        run_pass(3, 4, 1, -1, 1'b0, 6, 1'b0);
        run_pass(3, 4, 1, -1, 1'b0, -1, 1'b0);

        // Randomized passes with random gaps and downstream stalls
        rdy_mode = 1;
        for (int k = 0; k < 10; k++) begin
            rr = $urandom_range(2, 7);
            cc = $urandom_range(2, 7);
            pp = $urandom_range(0, cc - 2);
            for (int r = 0; r < 8; r++)
                for (int c = 0; c < 8; c++)
                    tab[r][c] = $urandom;
            run_pass(rr, cc, pp, -1, 1'b1, -1, 1'b0);
        end
        rdy_mode = 0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
